gate_tt_sweep: RTL and testbench



---
 rtl/gate_tt_sweep_if.sv | 48 ++++
 rtl/gate_tt_sweep.sv | 118 +++++++++++
 tb/tb_gate_tt_sweep.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_sweep_if.sv
// Stimulus/capture bundle between gate_tt_sweep and its controller.
// The slave modport is the sweep engine; the master modport is the bench/controller side.
// The signature output is named tbl because "table" is a reserved word.
// Optional GATE_TT_SWEEP_ERRCNT_EN adds the err_cnt mismatch counter.
interface gate_tt_sweep_if;
  logic       start;
  logic       s;
  logic       a;
  logic       b;
  logic [1:0] minterm;
  logic       busy;
  logic       done;
  logic [3:0] tbl;
  logic       match;
`ifdef GATE_TT_SWEEP_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  modport slave (
    input  start,
    input  s,
    output a,
    output b,
    output minterm,
    output busy,
    output done,
    output tbl,
`ifdef GATE_TT_SWEEP_ERRCNT_EN
    output err_cnt,
`endif
    output match
  );

  modport master (
    output start,
    output s,
    input  a,
    input  b,
    input  minterm,
    input  busy,
    input  done,
    input  tbl,
`ifdef GATE_TT_SWEEP_ERRCNT_EN
    input  err_cnt,
`endif
    input  match
  );
endinterface

// File: rtl/gate_tt_sweep.sv
// gate_tt_sweep: sweeps minterms 0..3 onto a/b, holds each for SETTLE extra cycles, samples s
// into a 4-bit truth-table signature and compares it with EXPECTED.
// Optional feature macro: GATE_TT_SWEEP_ERRCNT_EN (adds saturating err_cnt output).
module gate_tt_sweep #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [3:0]  EXPECTED = 4'b0111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_tt_sweep_if.slave        io_sweep
);

  localparam logic [7:0] SettleCnt = 8'(SETTLE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_minterm;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_tbl;
  logic       r_match;
  logic [3:0] w_tbl_next;
  logic [1:0] w_minterm_inc;
`ifdef GATE_TT_SWEEP_ERRCNT_EN
  logic [7:0] r_err_cnt;
`endif

  assign w_minterm_inc = r_minterm + 2'd1;

  // Signature with the current minterm's sample merged in; used at the sample edge.
  always_comb begin
    w_tbl_next             = r_tbl;
    w_tbl_next[r_minterm]  = io_sweep.s;
  end

  // Sweep controller; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_minterm <= 2'd0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tbl     <= 4'b0000;
      r_match   <= 1'b0;
`ifdef GATE_TT_SWEEP_ERRCNT_EN
      r_err_cnt <= 8'd0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (io_sweep.start) begin
            r_state   <= StRun;
            r_busy    <= 1'b1;
            r_cnt     <= 8'd0;
            r_minterm <= 2'd0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_tbl     <= 4'b0000;
            r_match   <= 1'b0;
          end
        end
        StRun: begin
          if (r_cnt != SettleCnt) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_tbl <= w_tbl_next;
            if (r_minterm == 2'd3) begin
              // match must be valid together with done, so compare the merged signature.
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (w_tbl_next == EXPECTED);
            end else begin
              r_minterm <= w_minterm_inc;
              r_a       <= w_minterm_inc[1];
              r_b       <= w_minterm_inc[0];
              r_cnt     <= 8'd0;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
`ifdef GATE_TT_SWEEP_ERRCNT_EN
          if (!r_match && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_sweep.a       = r_a;
  assign io_sweep.b       = r_b;
  assign io_sweep.minterm = r_minterm;
  assign io_sweep.busy    = r_busy;
  assign io_sweep.done    = r_done;
  assign io_sweep.tbl     = r_tbl;
  assign io_sweep.match   = r_match;
`ifdef GATE_TT_SWEEP_ERRCNT_EN
  assign io_sweep.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_gate_tt_sweep.sv
// Directed bench for gate_tt_sweep: one instance with SETTLE=1 and one with SETTLE=0,
// each driving a selectable gate model (NAND, constant 0, OR).
module tb_gate_tt_sweep;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   mode1;
  int   mode0;

  gate_tt_sweep_if sw1 ();
  gate_tt_sweep_if sw0 ();

  gate_tt_sweep #(.SETTLE(1), .EXPECTED(4'b0111)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sweep (sw1)
  );

  gate_tt_sweep #(.SETTLE(0), .EXPECTED(4'b0111)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sweep (sw0)
  );

  // 0: NAND, 1: constant 0, 2: OR
  function automatic logic gate_out(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~(a & b);
      1:       return 1'b0;
      default: return a | b;
    endcase
  endfunction

  assign sw1.s = gate_out(mode1, sw1.a, sw1.b);
  assign sw0.s = gate_out(mode0, sw0.a, sw0.b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start1();
    sw1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw1.start = 1'b0;
  endtask

  task automatic pulse_start0();
    sw0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw0.start = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sw1.done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done1_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic saw_done;
    n_checks  = 0;
    n_fail    = 0;
    mode1     = 0;
    mode0     = 1;
    sw1.start = 1'b0;
    sw0.start = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs1", 32'({sw1.busy, sw1.done, sw1.match, sw1.a, sw1.b, sw1.minterm, sw1.tbl}),
             32'd0);
    check_eq("rst_outs0", 32'({sw0.busy, sw0.done, sw0.match, sw0.a, sw0.b, sw0.minterm, sw0.tbl}),
             32'd0);
`ifdef GATE_TT_SWEEP_ERRCNT_EN
    check_eq("rst_err_cnt", 32'(sw0.err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // NAND, SETTLE=1: vectors every 2 cycles, done after E0+8
    mode1 = 0;
    pulse_start1();
    check_eq("nand_ab_m0", 32'({sw1.a, sw1.b}), 32'd0);
    check_eq("nand_busy", 32'(sw1.busy), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("nand_ab_m1", 32'({sw1.a, sw1.b}), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("nand_ab_m2", 32'({sw1.a, sw1.b}), 32'd2);
    repeat (2) @(negedge clk);
    check_eq("nand_ab_m3", 32'({sw1.a, sw1.b}), 32'd3);
    @(negedge clk);
    check_eq("nand_done_early", 32'(sw1.done), 32'd0);
    @(negedge clk);
    check_eq("nand_done", 32'(sw1.done), 32'd1);
    check_eq("nand_table", 32'(sw1.tbl), 32'h7);
    check_eq("nand_match", 32'(sw1.match), 32'd1);
    check_eq("nand_busy_done", 32'(sw1.busy), 32'd0);
    @(negedge clk);
    check_eq("nand_done_pulse", 32'(sw1.done), 32'd0);
    check_eq("nand_ab_hold", 32'({sw1.a, sw1.b, sw1.minterm}), 32'hF);

    // s tied low, SETTLE=0: done after E0+4
    mode0 = 1;
    pulse_start0();
    repeat (3) @(negedge clk);
    check_eq("zero_done_early", 32'(sw0.done), 32'd0);
    @(negedge clk);
    check_eq("zero_done", 32'(sw0.done), 32'd1);
    check_eq("zero_table", 32'(sw0.tbl), 32'h0);
    check_eq("zero_match", 32'(sw0.match), 32'd0);
    @(negedge clk);
`ifdef GATE_TT_SWEEP_ERRCNT_EN
    check_eq("err_cnt_1", 32'(sw0.err_cnt), 32'd1);
    for (int k = 0; k < 2; k++) begin
      pulse_start0();
      repeat (5) @(negedge clk);
    end
    check_eq("err_cnt_3", 32'(sw0.err_cnt), 32'd3);
`endif

    // OR gate against NAND pattern
    mode0 = 2;
    pulse_start0();
    repeat (4) @(negedge clk);
    check_eq("or_done", 32'(sw0.done), 32'd1);
    check_eq("or_table", 32'(sw0.tbl), 32'hE);
    check_eq("or_match", 32'(sw0.match), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("or_table_hold", 32'(sw0.tbl), 32'hE);
    check_eq("or_match_hold", 32'(sw0.match), 32'd0);
    check_eq("or_idle", 32'({sw0.busy, sw0.done}), 32'd0);

    // start held high, SETTLE=0: done every 6 cycles, no mid-sweep restart
    mode0 = 0;
    sw0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      check_eq($sformatf("held_done_%0d", i), 32'(sw0.done), 32'((i % 6) == 4));
      check_eq($sformatf("held_minterm_%0d", i), 32'(sw0.minterm),
               ((i % 6) < 4) ? 32'(i % 6) : 32'd3);
      @(negedge clk);
    end
    sw0.start = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-sweep at minterm 2
    mode1 = 0;
    pulse_start1();
    repeat (4) @(negedge clk);
    check_eq("abort_minterm", 32'(sw1.minterm), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_outs",
             32'({sw1.busy, sw1.done, sw1.match, sw1.a, sw1.b, sw1.minterm, sw1.tbl}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sw1.done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    pulse_start1();
    wait_done1(20);
    check_eq("after_abort_table", 32'(sw1.tbl), 32'h7);
    check_eq("after_abort_match", 32'(sw1.match), 32'd1);

    // start high while reset is held across an edge: no launch until reset is released
    @(negedge clk);
    rst_n     = 1'b0;
    sw1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_start_busy", 32'(sw1.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw1.start = 1'b0;
    check_eq("post_rst_busy", 32'(sw1.busy), 32'd1);
    wait_done1(20);
    check_eq("post_rst_table", 32'(sw1.tbl), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
